// File: rtl/csa_accumulator.sv
// csa_accumulator: streaming multi-operand adder with a carry-save running total,
// resolved by a single carry-propagate add on the last beat of each packet.
module csa_accumulator #(
    parameter int WIDTH = 4,
    parameter int LANES = 4,
    parameter int ACC_W = 12,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [LANES-1:0]       in_mask,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_ovf
);
    localparam int TW = ACC_W + 1;
    localparam int PW = $clog2(LANES + 1);
    // Largest element count that provably cannot wrap ACC_W, whatever the data.
    localparam logic [TW-1:0] LIMIT = TW'((2**ACC_W - 1) / (2**WIDTH - 1));

    typedef enum logic [1:0] {ACCUM, RESOLVE, HOLD} state_t;

    state_t state, state_nxt;
    logic rdy;
    logic [ACC_W-1:0] s, c, ns, nc, t, x;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [TW-1:0] tot, tot_nxt;
    logic [CNT_W:0] cnt_sum;
    logic [TW:0] tot_sum;
    logic [PW-1:0] pc;
    logic accept, handoff;

    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;

    always_comb begin
        ns = s;
        nc = c;
        t  = '0;
        x  = '0;
        pc = '0;
        for (int i = 0; i < LANES; i++) begin
            x  = in_mask[i] ? ACC_W'(in_data[i*WIDTH +: WIDTH]) : '0;
            t  = ns ^ nc ^ x;
            nc = ((ns & nc) | (ns & x) | (nc & x)) << 1;
            ns = t;
            pc = pc + PW'(in_mask[i]);
        end
    end

    assign cnt_sum = {1'b0, cnt} + (CNT_W+1)'(pc);
    assign tot_sum = {1'b0, tot} + (TW+1)'(pc);
    assign cnt_nxt = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    assign tot_nxt = tot_sum[TW] ? '1 : tot_sum[TW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   state_nxt = (accept && in_last) ? RESOLVE : ACCUM;
            RESOLVE: state_nxt = HOLD;
            HOLD:    state_nxt = out_ready ? ACCUM : HOLD;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = rdy && (state == ACCUM);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy       <= 1'b0;
            s         <= '0;
            c         <= '0;
            cnt       <= '0;
            tot       <= '0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            rdy <= 1'b1;
            if (accept) begin
                s   <= ns;
                c   <= nc;
                cnt <= cnt_nxt;
                tot <= tot_nxt;
            end
            if (state == RESOLVE) begin
                out_sum   <= s + c;
                out_count <= cnt;
                out_ovf   <= tot > LIMIT;
            end
            if (handoff) begin
                s   <= '0;
                c   <= '0;
                cnt <= '0;
                tot <= '0;
            end
        end
    end
endmodule
